pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator for the RV32 fetch stage.
- Produces the fetch address each cycle from four sources: reset vector, trap redirect, execute-stage jump, and a predicted return popped from an internal return-address stack (RAS).
- Supports a configurable sequential step (4, or 2 for compressed instructions) and reports misaligned redirect targets.
- Sits between the execute/CSR redirect logic and the instruction-fetch bus.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes; legal values are 2 and 4.
- RAS_DEPTH, 4, return-stack entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- trap_flag_i  in  1  trap/interrupt redirect request.
- trap_addr_i  in  ADDR_W  trap vector.
- jump_flag_i  in  1  resolved branch/jump redirect.
- jump_addr_i  in  ADDR_W  resolved target.
- hold_flag_i  in  1  pipeline stall; freeze PC.
- ras_push_i  in  1  call detected (JAL/JALR with rd=x1/x5).
- ras_push_addr_i  in  ADDR_W  return address to push.
- ras_pop_i  in  1  return detected at fetch; use predicted target.
- pc_o  out  ADDR_W  current fetch address.
- pc_pred_o  out  1  pc_o came from a RAS pop on the previous update.
- misalign_o  out  1  last redirect target was misaligned.
- ras_empty_o  out  1  RAS holds no entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset is synchronous and active-low, sampled only on the rising edge of clk. While rst=0:
  - pc_o=RESET_ADDR.
  - pc_pred_o=0, misalign_o=0.
  - RAS count=0, top pointer=0, so ras_empty_o=1 and ras_full_o=0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation overrides every other input in the same cycle.
- Next-PC selection, strict priority per cycle:
  1. Trap: pc_o<=trap_addr_i. RAS is flushed (count=0) and any push/pop in that cycle is ignored.
  2. Jump: pc_o<=jump_addr_i. RAS push/pop in that cycle is still applied.
  3. RAS pop, only when ras_pop_i=1, hold_flag_i=0 and the RAS is non-empty: pc_o<=top entry, pc_pred_o<=1.
  4. Hold: pc_o unchanged. Push and pop are suppressed, so the RAS is unchanged.
  5. Otherwise: pc_o<=pc_o+STEP. The sum wraps modulo 2^ADDR_W (0xFFFF_FFFC+4 gives 0).
- pc_pred_o<=0 for every source except the RAS pop.
- Redirect targets (trap and jump): bit0 is always cleared before loading pc_o.
  - When STEP=4, bit1 is cleared as well.
  - misalign_o<=1 for one cycle if any cleared bit was 1; otherwise misalign_o<=0.
  - RAS-pop and sequential updates also set misalign_o<=0.
- Latency: one cycle from redirect input to pc_o. No combinational path from any input to pc_o.
- RAS is a circular LIFO of RAS_DEPTH x ADDR_W entries. Updates apply only when not trapping and not held.
  - Push only: write ras_push_addr_i at top+1, top++, count++ saturating at RAS_DEPTH.
  - Push when full: overwrite the oldest entry (pointer wrap); count stays RAS_DEPTH.
  - Pop only: top--, count--.
  - Pop when empty: no RAS change. The pop request is ignored for next-PC selection, so the next lower priority applies.
  - Push and pop in the same cycle: overwrite the top entry with ras_push_addr_i; pointer and count unchanged.
    - The popped (old) top value is still used as next PC, unless a jump wins.
  - A jump together with a pop still pops: the prediction is consumed and the jump target wins.
- ras_empty_o = (count==0) and ras_full_o = (count==RAS_DEPTH). Both are registered state, not combinational from inputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles with jump_flag_i=1 -> pc_o=0x0, ras_empty_o=1. Release rst -> pc_o=0x0, 0x4, 0x8 on successive edges.
- Priority: trap_flag_i=1 (0x100) and jump_flag_i=1 (0x200) together -> pc_o=0x100 and the RAS is flushed. Next cycle jump only to 0x203 -> pc_o=0x200 with misalign_o=1 for exactly one cycle.
- Hold and wrap:
  - pc_o=0xFFFF_FFF8 with hold 3 cycles -> pc_o constant.
  - Release hold -> 0xFFFF_FFFC, then 0x0000_0000.
- RAS basic: push 0x40, then push 0x80, then pop -> pc_o=0x80 with pc_pred_o=1. Next pop -> pc_o=0x40. Next pop while empty -> pc_o=0x44, pc_pred_o=0.
- RAS overflow with RAS_DEPTH=4:
  - Push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full_o=1.
  - Four pops yield 0x50, 0x40, 0x30, 0x20, then ras_empty_o=1; 0x10 is lost.
- Simultaneous push+pop with top=0x30: push 0x90 and pop together -> pc_o=0x30, count unchanged. Next pop -> pc_o=0x90.
- STEP=2 build: sequential from 0x0 gives 0x2, 0x4. Jump to 0x107 -> pc_o=0x106, misalign_o=1.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side request/response bundle for the program-counter generator.
// The slave side is the PC generator; the master side is redirect/fetch control.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              trap_flag_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_flag_i;
  logic              ras_push_i;
  logic [ADDR_W-1:0] ras_push_addr_i;
  logic              ras_pop_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_pred_o;
  logic              misalign_o;
  logic              ras_empty_o;
  logic              ras_full_o;

  modport slave (
    input  trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
           ras_push_i, ras_push_addr_i, ras_pop_i,
    output pc_o, pc_pred_o, misalign_o, ras_empty_o, ras_full_o
  );

  modport master (
    output trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
           ras_push_i, ras_push_addr_i, ras_pop_i,
    input  pc_o, pc_pred_o, misalign_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// RV32 fetch program-counter generator with a circular return-address stack.
// Next PC priority: trap > jump > RAS pop > hold > sequential step.
// All outputs are registered; redirect targets take effect one cycle later.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                STEP       = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);
  // Low bits that a redirect target must have clear for the current step size.
  localparam logic [ADDR_W-1:0] LOW_MASK = (STEP == 4) ? ADDR_W'(3) : ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pred_q, pred_d;
  logic              mis_q, mis_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];

  logic              ras_upd;
  logic              push_eff;
  logic              pop_eff;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] redir_raw;

  // Decide which RAS operations actually happen this cycle.
  always_comb begin
    ras_upd  = !bus.trap_flag_i && !bus.hold_flag_i;
    push_eff = ras_upd && bus.ras_push_i;
    pop_eff  = ras_upd && bus.ras_pop_i && (cnt_q != '0);
  end

  // Next-PC selection and redirect alignment.
  always_comb begin
    pc_d      = pc_q + STEP_INC;
    pred_d    = 1'b0;
    mis_d     = 1'b0;
    redir_raw = bus.jump_addr_i;
    if (bus.trap_flag_i) begin
      redir_raw = bus.trap_addr_i;
    end
    if (bus.trap_flag_i || bus.jump_flag_i) begin
      pc_d  = redir_raw & ~LOW_MASK;
      mis_d = |(redir_raw & LOW_MASK);
    end else if (pop_eff) begin
      // Push+pop in one cycle still returns the old top before it is overwritten.
      pc_d   = ras_mem_q[top_q];
      pred_d = 1'b1;
    end else if (bus.hold_flag_i) begin
      pc_d = pc_q;
    end
  end

  // RAS pointer/count update; a trap flushes the stack.
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    if (bus.trap_flag_i) begin
      top_d = '0;
      cnt_d = '0;
    end else if (push_eff && pop_eff) begin
      wr_en = 1'b1;
    end else if (push_eff) begin
      // Incrementing past the newest entry lands on the oldest one when full.
      wr_en  = 1'b1;
      wr_ptr = top_q + PTR_W'(1);
      top_d  = wr_ptr;
      if (cnt_q != FULL_CNT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_eff) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_ADDR;
      pred_q <= 1'b0;
      mis_q  <= 1'b0;
      top_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pred_q <= pred_d;
      mis_q  <= mis_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
    end
  end

  // Return-stack storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      ras_mem_q[wr_ptr] <= bus.ras_push_addr_i;
    end
  end

  // Drive registered outputs.
  always_comb begin
    bus.pc_o        = pc_q;
    bus.pc_pred_o   = pred_q;
    bus.misalign_o  = mis_q;
    bus.ras_empty_o = (cnt_q == '0);
    bus.ras_full_o  = (cnt_q == FULL_CNT);
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one STEP=4 instance and one STEP=2 instance.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(32)) bus4 ();
  pc_gen_if #(.ADDR_W(32)) bus2 ();

  pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .STEP(4), .RAS_DEPTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .STEP(2), .RAS_DEPTH(4)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    bus4.trap_flag_i     = 1'b0;
    bus4.trap_addr_i     = '0;
    bus4.jump_flag_i     = 1'b0;
    bus4.jump_addr_i     = '0;
    bus4.hold_flag_i     = 1'b0;
    bus4.ras_push_i      = 1'b0;
    bus4.ras_push_addr_i = '0;
    bus4.ras_pop_i       = 1'b0;
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] exp_pc);
    idle4();
    bus4.ras_push_i      = 1'b1;
    bus4.ras_push_addr_i = a;
    tick();
    chk("push_pc", bus4.pc_o, exp_pc);
    idle4();
  endtask

  task automatic pop4(input logic [31:0] exp_pc, input logic exp_pred);
    idle4();
    bus4.ras_pop_i = 1'b1;
    tick();
    chk("pop_pc", bus4.pc_o, exp_pc);
    chk("pop_pred", {31'b0, bus4.pc_pred_o}, {31'b0, exp_pred});
    idle4();
  endtask

  initial begin
    idle4();
    bus2.trap_flag_i = 1'b0; bus2.trap_addr_i = '0;
    bus2.jump_flag_i = 1'b0; bus2.jump_addr_i = '0;
    bus2.hold_flag_i = 1'b0; bus2.ras_push_i  = 1'b0;
    bus2.ras_push_addr_i = '0; bus2.ras_pop_i = 1'b0;
    rst  = 1'b0;
    rst2 = 1'b0;

    // Reset overrides a pending jump.
    bus4.jump_flag_i = 1'b1;
    bus4.jump_addr_i = 32'h200;
    tick();
    tick();
    chk("rst_pc", bus4.pc_o, 32'h0);
    chk("rst_empty", {31'b0, bus4.ras_empty_o}, 32'd1);
    chk("rst_full", {31'b0, bus4.ras_full_o}, 32'd0);
    chk("rst_pred", {31'b0, bus4.pc_pred_o}, 32'd0);
    chk("rst_mis", {31'b0, bus4.misalign_o}, 32'd0);
    idle4();
    rst = 1'b1;
    tick(); chk("seq1", bus4.pc_o, 32'h4);
    tick(); chk("seq2", bus4.pc_o, 32'h8);

    // Trap beats jump and flushes the stack.
    push4(32'h40, 32'hC);
    chk("one_entry_empty", {31'b0, bus4.ras_empty_o}, 32'd0);
    bus4.trap_flag_i = 1'b1; bus4.trap_addr_i = 32'h100;
    bus4.jump_flag_i = 1'b1; bus4.jump_addr_i = 32'h200;
    bus4.ras_push_i  = 1'b1; bus4.ras_push_addr_i = 32'h55;
    tick();
    chk("trap_pc", bus4.pc_o, 32'h100);
    chk("trap_flush", {31'b0, bus4.ras_empty_o}, 32'd1);
    chk("trap_mis", {31'b0, bus4.misalign_o}, 32'd0);
    idle4();
    bus4.jump_flag_i = 1'b1; bus4.jump_addr_i = 32'h203;
    tick();
    chk("jmp_mis_pc", bus4.pc_o, 32'h200);
    chk("jmp_mis", {31'b0, bus4.misalign_o}, 32'd1);
    idle4();
    tick();
    chk("after_mis_pc", bus4.pc_o, 32'h204);
    chk("mis_clear", {31'b0, bus4.misalign_o}, 32'd0);

    // Hold and address wrap.
    bus4.jump_flag_i = 1'b1; bus4.jump_addr_i = 32'hFFFF_FFF8;
    tick();
    chk("wrap_jmp", bus4.pc_o, 32'hFFFF_FFF8);
    idle4();
    bus4.hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", bus4.pc_o, 32'hFFFF_FFF8);
    end
    idle4();
    tick(); chk("wrap1", bus4.pc_o, 32'hFFFF_FFFC);
    tick(); chk("wrap0", bus4.pc_o, 32'h0);

    // Basic push/pop and pop-on-empty fallthrough.
    push4(32'h40, 32'h4);
    push4(32'h80, 32'h8);
    pop4(32'h80, 1'b1);
    pop4(32'h40, 1'b1);
    chk("basic_empty", {31'b0, bus4.ras_empty_o}, 32'd1);
    pop4(32'h44, 1'b0);

    // Overflow drops the oldest entry.
    push4(32'h10, 32'h48);
    push4(32'h20, 32'h4C);
    push4(32'h30, 32'h50);
    push4(32'h40, 32'h54);
    chk("full4", {31'b0, bus4.ras_full_o}, 32'd1);
    push4(32'h50, 32'h58);
    chk("full5", {31'b0, bus4.ras_full_o}, 32'd1);
    pop4(32'h50, 1'b1);
    chk("not_full", {31'b0, bus4.ras_full_o}, 32'd0);
    pop4(32'h40, 1'b1);
    pop4(32'h30, 1'b1);
    pop4(32'h20, 1'b1);
    chk("ovf_empty", {31'b0, bus4.ras_empty_o}, 32'd1);
    pop4(32'h24, 1'b0);

    // Simultaneous push and pop replaces the top entry.
    push4(32'h10, 32'h28);
    push4(32'h20, 32'h2C);
    push4(32'h30, 32'h30);
    bus4.ras_push_i = 1'b1; bus4.ras_push_addr_i = 32'h90;
    bus4.ras_pop_i  = 1'b1;
    tick();
    chk("pp_pc", bus4.pc_o, 32'h30);
    chk("pp_pred", {31'b0, bus4.pc_pred_o}, 32'd1);
    idle4();
    pop4(32'h90, 1'b1);
    pop4(32'h20, 1'b1);
    pop4(32'h10, 1'b1);
    chk("pp_empty", {31'b0, bus4.ras_empty_o}, 32'd1);

    // Jump with pop consumes the prediction.
    push4(32'hA0, 32'h14);
    bus4.jump_flag_i = 1'b1; bus4.jump_addr_i = 32'h300;
    bus4.ras_pop_i   = 1'b1;
    tick();
    chk("jp_pc", bus4.pc_o, 32'h300);
    chk("jp_pred", {31'b0, bus4.pc_pred_o}, 32'd0);
    chk("jp_empty", {31'b0, bus4.ras_empty_o}, 32'd1);
    idle4();

    // Hold suppresses a pop.
    push4(32'h70, 32'h304);
    bus4.hold_flag_i = 1'b1; bus4.ras_pop_i = 1'b1;
    tick();
    chk("hp_pc", bus4.pc_o, 32'h304);
    chk("hp_pred", {31'b0, bus4.pc_pred_o}, 32'd0);
    chk("hp_empty", {31'b0, bus4.ras_empty_o}, 32'd0);
    idle4();
    pop4(32'h70, 1'b1);

    // Mid-run reset beats a trap.
    rst = 1'b0;
    bus4.trap_flag_i = 1'b1; bus4.trap_addr_i = 32'h500;
    tick();
    chk("mrst_pc", bus4.pc_o, 32'h0);
    chk("mrst_pred", {31'b0, bus4.pc_pred_o}, 32'd0);
    idle4();
    rst = 1'b1;

    // STEP=2 instance.
    chk("s2_rst_pc", bus2.pc_o, 32'h0);
    rst2 = 1'b1;
    tick(); chk("s2_seq1", bus2.pc_o, 32'h2);
    tick(); chk("s2_seq2", bus2.pc_o, 32'h4);
    bus2.jump_flag_i = 1'b1; bus2.jump_addr_i = 32'h107;
    tick();
    chk("s2_jmp_pc", bus2.pc_o, 32'h106);
    chk("s2_jmp_mis", {31'b0, bus2.misalign_o}, 32'd1);
    bus2.jump_addr_i = 32'h10A;
    tick();
    chk("s2_al_pc", bus2.pc_o, 32'h10A);
    chk("s2_al_mis", {31'b0, bus2.misalign_o}, 32'd0);
    bus2.jump_flag_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
